// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, response and memory-port signal bundle of the arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [3:0]    dbg_be;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, mem_ready;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          gnt_id, busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    input  mem_ready, mem_rdata,
    output cpu_ack, cpu_err, cpu_rdata, dbg_ack, dbg_err, dbg_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, gnt_id, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    output mem_ready, mem_rdata,
    input  cpu_ack, cpu_err, cpu_rdata, dbg_ack, dbg_err, dbg_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, gnt_id, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises cpu and debug accesses onto one memory port with a watchdog
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] TO   = 8'(TIMEOUT);
  logic [1:0]    state_q, state_d;
  logic          last_q, last_d, gnt_q, gnt_d, busy_q, busy_d;
  logic          cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
  logic          cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d, done_data;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic          both, win, timed_out, done;
  assign both      = bus.cpu_req & bus.dbg_req;
  assign win       = both ? ~last_q : bus.dbg_req;
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timed_out = ~bus.mem_ready & (cnt_inc == TO);
  assign done      = (state_q == BUSY) & (bus.mem_ready | timed_out);
  assign done_data = timed_out ? DW'(32'hDEAD_BEEF) : bus.mem_rdata;
  // Next-state: grant in IDLE, wait for ready or watchdog in BUSY, single ack cycle in RESP
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_err_d   = 1'b0;
    if (state_q == IDLE && (bus.cpu_req | bus.dbg_req)) begin
      state_d     = BUSY;
      gnt_d       = win;
      last_d      = both ? win : last_q;
      cnt_d       = '0;
      mem_en_d    = 1'b1;
      mem_we_d    = win ? bus.dbg_we : bus.cpu_we;
      mem_be_d    = win ? bus.dbg_be : bus.cpu_be;
      mem_addr_d  = win ? bus.dbg_addr : bus.cpu_addr;
      mem_wdata_d = win ? bus.dbg_wdata : bus.cpu_wdata;
    end else if (state_q == BUSY) begin
      cnt_d = bus.mem_ready ? cnt_q : cnt_inc;
      if (done) begin
        state_d   = RESP;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        cpu_ack_d = ~gnt_q;
        dbg_ack_d = gnt_q;
        cpu_err_d = ~gnt_q & timed_out;
        dbg_err_d = gnt_q & timed_out;
        if (timed_out | ~mem_we_q) begin
          cpu_rdata_d = gnt_q ? cpu_rdata_q : done_data;
          dbg_rdata_d = gnt_q ? done_data : dbg_rdata_q;
        end
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end
  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_err_q   <= cpu_err_d;
      dbg_err_q   <= dbg_err_d;
    end
  end
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_err   = dbg_err_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.gnt_id    = gnt_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios checked against a transaction-level model every cycle
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // memory responder: ready after mem_lat cycles of mem_en (0 = never), or forced level when manual
  logic        auto_mem = 1'b1, force_ready = 1'b0;
  int          mem_lat = 1, en_cyc = 0;
  logic [31:0] mem_data = 32'h0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (auto_mem && bus.mem_en) begin
        en_cyc++;
        bus.mem_ready = (en_cyc == mem_lat);
        bus.mem_rdata = mem_data;
        if (bus.mem_ready) mem_data = mem_data + 32'h1111_1111;
      end else begin
        en_cyc = 0;
        bus.mem_ready = auto_mem ? 1'b0 : force_ready;
        bus.mem_rdata = 32'hBAD0_0BAD;
      end
    end
  end
  // model: one outstanding access at a time, tracked by owner and number of BUSY cycles spent
  logic        started = 1'b0;
  logic        m_active, m_resp, m_last, w;
  int          m_age;
  logic        e_en, e_we, e_gnt, e_busy, e_cack, e_dack, e_cerr, e_derr;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_crd, e_drd, d;
  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (!rst_n) begin
      m_active = 0; m_resp = 0; m_last = 1; m_age = 0;
      e_en = 0; e_we = 0; e_gnt = 0; e_busy = 0; e_cack = 0; e_dack = 0; e_cerr = 0; e_derr = 0;
      e_be = 0; e_addr = 0; e_wdata = 0; e_crd = 0; e_drd = 0;
    end else begin
      e_cack = 0; e_dack = 0; e_cerr = 0; e_derr = 0;
      if (m_resp) begin
        m_resp = 0;
        e_busy = 0;
      end else if (m_active) begin
        m_age++;
        if (bus.mem_ready || m_age >= TIMEOUT) begin
          d = !bus.mem_ready ? 32'hDEAD_BEEF : e_we ? (e_gnt ? e_drd : e_crd) : bus.mem_rdata;
          if (e_gnt) begin e_drd = d; e_dack = 1; e_derr = !bus.mem_ready; end
          else begin e_crd = d; e_cack = 1; e_cerr = !bus.mem_ready; end
          e_en = 0; e_we = 0; m_active = 0; m_resp = 1;
        end
      end else if (bus.cpu_req || bus.dbg_req) begin
        w = (bus.cpu_req && bus.dbg_req) ? !m_last : bus.dbg_req;
        if (bus.cpu_req && bus.dbg_req) m_last = w;
        e_gnt = w; e_en = 1; e_busy = 1; m_active = 1; m_age = 0;
        e_we = w ? bus.dbg_we : bus.cpu_we;
        e_be = w ? bus.dbg_be : bus.cpu_be;
        e_addr = w ? bus.dbg_addr : bus.cpu_addr;
        e_wdata = w ? bus.dbg_wdata : bus.cpu_wdata;
      end
    end
  end
  // every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("mem_en", bus.mem_en, e_en);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_be", bus.mem_be, e_be);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("gnt_id", bus.gnt_id, e_gnt);
      chk("busy", bus.busy, e_busy);
      chk("cpu_ack", bus.cpu_ack, e_cack);
      chk("dbg_ack", bus.dbg_ack, e_dack);
      chk("cpu_err", bus.cpu_err, e_cerr);
      chk("dbg_err", bus.dbg_err, e_derr);
      chk("cpu_rdata", bus.cpu_rdata, e_crd);
      chk("dbg_rdata", bus.dbg_rdata, e_drd);
    end
  end
  task automatic start(input logic who, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_be = be; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_be = be; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask
  task automatic stop();
    bus.cpu_req = 0;
    bus.dbg_req = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL sim_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end
  int nack;
  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_be = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_be = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    idle(3);
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_gnt", bus.gnt_id, 0);
    chk("reset_cpu_rdata", bus.cpu_rdata, 0);
    rst_n = 1;
    idle(1);
    // single CPU read, ready two cycles after mem_en
    mem_lat = 2; mem_data = 32'h1234_5678;
    start(0, 0, 4'hF, 32'h10, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("rd_dbg_ack", bus.dbg_ack, 0);
      if (c <= 2) chk("rd_mem_en", bus.mem_en, 1);
      if (c == 3) begin
        chk("rd_cpu_ack", bus.cpu_ack, 1);
        chk("rd_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
        chk("rd_cpu_err", bus.cpu_err, 0);
        stop();
      end
    end
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(1);
    // contention right after reset, zero-wait memory
    mem_lat = 1; mem_data = 32'h1000_0000;
    start(0, 0, 4'hF, 32'h40, 32'h0);
    start(1, 0, 4'hF, 32'h80, 32'h0);
    nack = 0;
    for (int c = 1; c <= 14 && nack < 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("cont_first_gnt", bus.gnt_id, 0);
      if (bus.cpu_ack || bus.dbg_ack) begin
        chk("cont_ack_cycle", c, 3 * nack + 2);
        chk("cont_owner", bus.dbg_ack, nack % 2);
        nack++;
      end
    end
    chk("cont_acks", nack, 4);
    stop();
    chk("cont_cpu_rdata", bus.cpu_rdata, 32'h3222_2222);
    idle(2);
    // debug write held for the whole BUSY phase
    mem_lat = 3;
    start(1, 1, 4'b0011, 32'h100, 32'hCAFE_F00D);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_mem_be", bus.mem_be, 4'b0011);
        chk("wr_mem_addr", bus.mem_addr, 32'h100);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
      end else begin
        chk("wr_dbg_ack", bus.dbg_ack, 1);
        chk("wr_gnt", bus.gnt_id, 1);
        chk("wr_dbg_rdata", bus.dbg_rdata, 32'h4333_3333);
        stop();
      end
    end
    idle(2);
    // watchdog: memory never ready
    mem_lat = 0;
    start(0, 0, 4'hF, 32'h200, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1 || c == 15) chk("wd_mem_en", bus.mem_en, 1);
      if (c == 15) chk("wd_no_early_ack", bus.cpu_ack, 0);
      if (c == 16) begin
        chk("wd_cpu_ack", bus.cpu_ack, 1);
        chk("wd_cpu_err", bus.cpu_err, 1);
        chk("wd_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("wd_mem_en_low", bus.mem_en, 0);
        stop();
      end
    end
    idle(1);
    mem_lat = 1; mem_data = 32'h5555_AAAA;
    start(0, 0, 4'hF, 32'h204, 32'h0);
    idle(2);
    chk("wd_next_ack", bus.cpu_ack, 1);
    chk("wd_next_err", bus.cpu_err, 0);
    chk("wd_next_rdata", bus.cpu_rdata, 32'h5555_AAAA);
    stop();
    idle(2);
    // ready in the same cycle the counter reaches TIMEOUT
    mem_lat = 15; mem_data = 32'h7777_0001;
    start(0, 0, 4'hF, 32'h208, 32'h0);
    idle(16);
    chk("bnd_ack", bus.cpu_ack, 1);
    chk("bnd_err", bus.cpu_err, 0);
    chk("bnd_rdata", bus.cpu_rdata, 32'h7777_0001);
    stop();
    idle(1);
    // mem_ready pulsed in IDLE
    auto_mem = 0; force_ready = 1;
    idle(3);
    chk("idle_rdy_busy", bus.busy, 0);
    chk("idle_rdy_mem_en", bus.mem_en, 0);
    chk("idle_rdy_rdata", bus.cpu_rdata, 32'h7777_0001);
    force_ready = 0; auto_mem = 1;
    idle(1);
    // reset during BUSY drops the access
    mem_lat = 0;
    start(1, 0, 4'hF, 32'h300, 32'h0);
    idle(3);
    chk("rst_pre_busy", bus.busy, 1);
    rst_n = 0;
    stop();
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dbg_ack", bus.dbg_ack, 0);
    chk("rst_gnt", bus.gnt_id, 0);
    idle(1);
    rst_n = 1;
    idle(1);
    mem_lat = 1;
    start(0, 0, 4'hF, 32'h40, 32'h0);
    start(1, 0, 4'hF, 32'h80, 32'h0);
    @(negedge clk);
    chk("rst_cont_gnt", bus.gnt_id, 0);
    @(negedge clk);
    chk("rst_cont_cpu_ack", bus.cpu_ack, 1);
    stop();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
